cfu_issue: RTL
==============

# cfu_issue

CPU-side initiator for the CFU port: takes a decoded custom-instruction from the execute stage, drives `cfu_valid_o`/`cfu_ctrl_o`/operands to the CFU, and waits for completion. It holds the pipeline while the request is outstanding, and returns the captured result to writeback. It sits between the core's EX stage and the `cfu` responder and is the only block that drives the CFU request lines.

## Interface
- `TIMEOUT_CYCLES`, 255: REQ cycles before abort (used only with `CFU_TIMEOUT_EN`); width 8..16 bits.
- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `stall_i` in 1: downstream writeback hold.
- `issue_i` in 1: EX holds a CFU instruction; sampled only in IDLE.
- `funct3_i` in 3: instruction funct3.
- `funct7_i` in 7: instruction funct7.
- `rs1_data_i` in `XLEN`: operand 1.
- `rs2_data_i` in `XLEN`: operand 2.
- `rd_i` in 5: destination register.
- `pipe_stall_o` out 1: freeze EX and earlier stages.
- `wb_valid_o` out 1: result valid for writeback.
- `wb_rd_o` out 5: destination of result.
- `wb_data_o` out `XLEN`: result.
- `err_o` out 1: request aborted by timeout.
- `cfu_valid_o` out 1: request valid to CFU.
- `cfu_ctrl_o` out `CFU_CTRL_WIDTH`: `{funct7, funct3}`; [2:0]=funct3, [9:3]=funct7, upper bits 0.
- `cfu_src1_o` out `XLEN`: operand 1 to CFU.
- `cfu_src2_o` out `XLEN`: operand 2 to CFU.
- `cfu_stall_o` out 1: equals `stall_i`.
- `cfu_stall_i` in 1: CFU busy; result not ready.
- `cfu_rslt_i` in `XLEN`: CFU result.

## Operation
- States are IDLE, REQ and DONE. All outputs except `pipe_stall_o` and `cfu_stall_o` are registered.
- **IDLE**
  - On `issue_i=1`, latch funct3, funct7, rs1, rs2 and rd, then go to REQ.
  - `pipe_stall_o = issue_i`, combinationally, in the issue cycle.
- **REQ**
  - `cfu_valid_o=1`. Ctrl and operands are held stable.
  - On `cfu_stall_i=0`, capture `cfu_rslt_i` into `wb_data_o`, drop `cfu_valid_o` on the next edge and go to DONE.
  - While `cfu_stall_i=1`, remain in REQ.
- **DONE**
  - `wb_valid_o=1`.
  - If `stall_i=0`, writeback accepts this cycle and the next state is IDLE.
  - If `stall_i=1`, hold `wb_valid_o`, `wb_rd_o` and `wb_data_o` unchanged.
- `pipe_stall_o=1` in REQ, and in DONE while `stall_i=1`. It is 0 in the DONE acceptance cycle, so the next instruction advances.
- `issue_i` is ignored outside IDLE.
- **Reset** (asynchronous, at any time, including mid-REQ):
  - State goes to IDLE.
  - All registered outputs go to 0: `cfu_valid_o`, `cfu_ctrl_o`, `cfu_src*_o`, `wb_*`, `err_o`.
  - An in-flight request is dropped with no writeback.
- **rd=x0:** the writeback still carries `wb_rd_o=0`; the register file discards it.

## Timing
- Combinational CFU (`cfu_stall_i=0` always):
  - issue at cycle 0;
  - `cfu_valid_o` high in cycle 1, result captured at the end of cycle 1;
  - `wb_valid_o` high in cycle 2.
  - Minimum latency is 2 cycles, and at most one request is outstanding at a time.
- Multi-cycle CFU: `wb_valid_o` rises one cycle after the first REQ cycle with `cfu_stall_i=0`.
- `cfu_valid_o` is high for exactly 1 + (number of `cfu_stall_i=1` cycles) cycles.
- `stall_i` during REQ has no effect on the request. Only DONE waits on it.

## Configuration
- **`CFU_TIMEOUT_EN` defined:**
  - An 8..16-bit counter clears on entry to REQ and increments in each REQ cycle with `cfu_stall_i=1`.
  - When the count reaches `TIMEOUT_CYCLES`, drop `cfu_valid_o`, set `wb_data_o=0`, and go to DONE.
  - `err_o` is high for the whole DONE residency of that request.
- **Undefined:** no counter; REQ waits indefinitely; `err_o` is tied to 0.

## Structure
- `XLEN` and `CFU_CTRL_WIDTH` come from `config.vh`.
- Add state encodings to `config.vh` as the `CFU_ISSUE_IDLE`, `CFU_ISSUE_REQ` and `CFU_ISSUE_DONE` defines (2 bits).
- The only sub-module is `cfu_watchdog`, the timeout counter. It is instantiated only under `CFU_TIMEOUT_EN`.

## Test plan
- Reset, then release → all outputs 0, state IDLE.
- funct3=1, funct7=0, rs1=5, rs2=7, rd=3; CFU adder, combinational → `cfu_ctrl_o`=10'h001 in cycle 1; `wb_valid_o`, `wb_rd_o`=3, `wb_data_o`=12 in cycle 2; `pipe_stall_o` high in cycles 0–1 only.
- funct3=2, rs1=3, rs2=5; CFU holds `cfu_stall_i=1` for 4 cycles → `cfu_valid_o` high 5 cycles with stable operands; `wb_data_o`=32'hFFFF_FFFE.
- Result in DONE with `stall_i=1` for 3 cycles → `wb_valid_o`/data held 4 cycles; `pipe_stall_o` high throughout; IDLE after release.
- `rst_i` pulsed in the 2nd REQ cycle → `cfu_valid_o`=0 immediately; no `wb_valid_o`; the next issue completes normally.
- `CFU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `cfu_stall_i` stuck at 1 → after 8 REQ cycles, `wb_valid_o`=1, `wb_data_o`=0, `err_o`=1.

Source files
------------

// File: rtl/cfu_issue_pkg.sv
// cfu_issue_pkg: shared widths, state encodings and helpers for the CFU issue initiator.
`default_nettype none

package cfu_issue_pkg;

  localparam int XLEN           = 32;
  localparam int CFU_CTRL_WIDTH = 10;

  localparam logic [1:0] CFU_ISSUE_IDLE = 2'd0;
  localparam logic [1:0] CFU_ISSUE_REQ  = 2'd1;
  localparam logic [1:0] CFU_ISSUE_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = CFU_ISSUE_IDLE,
    ST_REQ  = CFU_ISSUE_REQ,
    ST_DONE = CFU_ISSUE_DONE
  } state_t;

  // ctrl layout: [2:0]=funct3, [9:3]=funct7, anything above is zero
  function automatic logic [CFU_CTRL_WIDTH-1:0] pack_ctrl(input logic [6:0] funct7,
                                                          input logic [2:0] funct3);
    return CFU_CTRL_WIDTH'({funct7, funct3});
  endfunction

  // Watchdog counter width: enough for the limit, clamped to 8..16 bits
  function automatic int wd_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cfu_watchdog.sv
// cfu_watchdog: counts stalled REQ cycles and flags the cycle that reaches the limit.
`default_nettype none

module cfu_watchdog
  import cfu_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CNT_W = wd_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // Fires on the stalled cycle whose increment would make the count hit the limit
  assign expire = count_en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cfu_issue.sv
// cfu_issue: EX-stage initiator for the CFU port (IDLE -> REQ -> DONE).
// Optional request timeout enabled by defining CFU_TIMEOUT_EN.
`default_nettype none

module cfu_issue
  import cfu_issue_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      issue_i,
  input  logic [2:0]                funct3_i,
  input  logic [6:0]                funct7_i,
  input  logic [XLEN-1:0]           rs1_data_i,
  input  logic [XLEN-1:0]           rs2_data_i,
  input  logic [4:0]                rd_i,
  output logic                      pipe_stall_o,
  output logic                      wb_valid_o,
  output logic [4:0]                wb_rd_o,
  output logic [XLEN-1:0]           wb_data_o,
  output logic                      err_o,
  output logic                      cfu_valid_o,
  output logic [CFU_CTRL_WIDTH-1:0] cfu_ctrl_o,
  output logic [XLEN-1:0]           cfu_src1_o,
  output logic [XLEN-1:0]           cfu_src2_o,
  output logic                      cfu_stall_o,
  input  logic                      cfu_stall_i,
  input  logic [XLEN-1:0]           cfu_rslt_i
);

  state_t     state;
  logic [4:0] rd_q;
  logic       timeout;

`ifdef CFU_TIMEOUT_EN
  logic err_q;

  cfu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    ((state == ST_IDLE) && issue_i),
    .count_en ((state == ST_REQ) && cfu_stall_i),
    .expire   (timeout)
  );

  assign err_o = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign err_o          = 1'b0;
`endif

  assign cfu_stall_o = stall_i;

  always_comb begin
    pipe_stall_o = 1'b0;
    case (state)
      ST_IDLE: pipe_stall_o = issue_i;
      ST_REQ:  pipe_stall_o = 1'b1;
      ST_DONE: pipe_stall_o = stall_i;
      default: pipe_stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rd_q        <= '0;
      cfu_valid_o <= 1'b0;
      cfu_ctrl_o  <= '0;
      cfu_src1_o  <= '0;
      cfu_src2_o  <= '0;
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
`ifdef CFU_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_i) begin
            cfu_ctrl_o  <= pack_ctrl(funct7_i, funct3_i);
            cfu_src1_o  <= rs1_data_i;
            cfu_src2_o  <= rs2_data_i;
            rd_q        <= rd_i;
            cfu_valid_o <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!cfu_stall_i) begin
            wb_data_o   <= cfu_rslt_i;
            wb_rd_o     <= rd_q;
            wb_valid_o  <= 1'b1;
            cfu_valid_o <= 1'b0;
            state       <= ST_DONE;
          end else if (timeout) begin
            // Abandon the request: writeback still happens, with zero data and err
            wb_data_o   <= '0;
            wb_rd_o     <= rd_q;
            wb_valid_o  <= 1'b1;
            cfu_valid_o <= 1'b0;
`ifdef CFU_TIMEOUT_EN
            err_q       <= 1'b1;
`endif
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!stall_i) begin
            wb_valid_o <= 1'b0;
`ifdef CFU_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
